// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned BCD_MAX = 32'd9999;
    localparam logic [15:0] SAT_BCD = 16'h9999;

    function automatic logic exceeds_bcd_max(input logic [31:0] value);
        return (value > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_digit_adjust
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Conditional +3 so the following left shift carries correctly into the next digit
    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: one bit per cycle, result held until consumed.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W      = 13,
    parameter int DIGITS = 4
) (
    input  logic                  fastclock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [W-1:0]          bin_in,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_e          state_r;
    logic [W-1:0]    bin_r;
    logic [SW-1:0]   scratch_r;
    logic [SW-1:0]   adj_s;
    logic [SW-1:0]   scratch_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic            ovf_pend_r;
    logic            carry_r;
    logic            accept_s;
    logic            out_valid_r;
    logic [SW-1:0]   bcd_out_r;
    logic            ovf_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (scratch_r[4*g +: 4]),
            .adjusted (adj_s[4*g +: 4])
        );
    end

    assign scratch_nxt_s = {adj_s[SW-2:0], bin_r[W-1]};
    assign in_ready      = (state_r == IDLE);
    assign accept_s      = in_valid & in_ready;
    assign out_valid     = out_valid_r;
    assign bcd_out       = bcd_out_r;
    assign ovf           = ovf_r;

    // FSM, shift datapath and registered result; a bit falling out of digit 3 also marks overflow
    always_ff @(posedge fastclock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            bin_r       <= '0;
            scratch_r   <= '0;
            cnt_r       <= '0;
            ovf_pend_r  <= 1'b0;
            carry_r     <= 1'b0;
            out_valid_r <= 1'b0;
            bcd_out_r   <= '0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        bin_r      <= bin_in;
                        scratch_r  <= '0;
                        cnt_r      <= CW'(W - 1);
                        ovf_pend_r <= exceeds_bcd_max(32'(bin_in));
                        carry_r    <= 1'b0;
                        state_r    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_r <= scratch_nxt_s;
                    bin_r     <= {bin_r[W-2:0], 1'b0};
                    carry_r   <= carry_r | adj_s[SW-1];
                    if (cnt_r == '0) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        ovf_r       <= ovf_pend_r | carry_r;
                        bcd_out_r   <= (ovf_pend_r | carry_r) ? SAT_BCD : scratch_r;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
